// File: rtl/mem_stream_pkg.sv
// Shared state encoding and default widths for the memory read streamer.
package mem_stream_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } stream_state_e;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry output buffer; head entry drives dout directly so it stays stable while stalled.
module skid_fifo2 #(
  parameter int unsigned data_width = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [data_width-1:0] din,
  input  logic                  pop,
  output logic [data_width-1:0] dout,
  output logic                  valid,
  output logic                  empty,
  output logic                  full,
  output logic [1:0]            occupancy
);

  logic [data_width-1:0] head_q, head_d;
  logic [data_width-1:0] tail_q, tail_d;
  logic [1:0]            occ_q, occ_d;
  logic                  valid_q, empty_q, full_q;
  logic                  do_pop;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    do_pop = pop && (occ_q != 2'd0);
    case ({push, do_pop})
      2'b10: begin
        // a push into a full buffer is dropped; the caller never issues one
        if (occ_q == 2'd0) begin
          head_d = din;
          occ_d  = 2'd1;
        end else if (occ_q == 2'd1) begin
          tail_d = din;
          occ_d  = 2'd2;
        end
      end
      2'b01: begin
        if (occ_q == 2'd2) head_d = tail_q;
        occ_d = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          head_d = din;
        end else begin
          head_d = tail_q;
          tail_d = din;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= 2'd0;
      valid_q <= 1'b0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
      valid_q <= (occ_d != 2'd0);
      empty_q <= (occ_d == 2'd0);
      full_q  <= (occ_d == 2'd2);
    end
  end

  assign dout      = head_q;
  assign valid     = valid_q;
  assign empty     = empty_q;
  assign full      = full_q;
  assign occupancy = occ_q;

endmodule

// File: rtl/mem_read_streamer.sv
// Streams a burst of words from an external synchronous RAM to a valid/ready consumer.
module mem_read_streamer
  import mem_stream_pkg::*;
#(
  parameter int unsigned data_width = DEFAULT_DATA_WIDTH,
  parameter int unsigned addr_width = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [addr_width-1:0] base_addr,
  input  logic [addr_width:0]   count,
  output logic [addr_width-1:0] ram_read_address,
  input  logic [data_width-1:0] ram_dout,
  output logic [data_width-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  stream_state_e         state_q, state_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic [addr_width:0]   remaining_q, remaining_d;
  logic                  in_flight_q, in_flight_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  xfer;
  logic                  fifo_push, fifo_empty, fifo_full;
  logic [1:0]            fifo_occ, slots_used;
  logic                  issue_ok;

  assign xfer       = out_valid && out_ready;
  assign fifo_push  = in_flight_q && (!fifo_full || xfer);
  assign slots_used = fifo_occ + 2'(in_flight_q);
  // a read may be issued only if its word is guaranteed a buffer slot on return
  assign issue_ok   = (slots_used < 2'd2) || ((slots_used == 2'd2) && xfer);

  skid_fifo2 #(.data_width(data_width)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .din       (ram_dout),
    .pop       (xfer),
    .dout      (out_data),
    .valid     (out_valid),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .occupancy (fifo_occ)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    in_flight_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d      = base_addr;
          remaining_d = count;
          state_d     = (count == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        // address register always holds the next address to read
        if (issue_ok) begin
          in_flight_d = 1'b1;
          addr_d      = addr_q + addr_width'(1);
          remaining_d = remaining_q - (addr_width+1)'(1);
          if (remaining_q == (addr_width+1)'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty && !in_flight_q) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      in_flight_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      in_flight_q <= in_flight_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign ram_read_address = addr_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule

// File: tb/tb_mem_read_streamer.sv
// Randomized bench for mem_read_streamer with a queue-based expected-word model.
module tb_mem_read_streamer;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset, start, out_ready;
  logic [AW-1:0] base_addr, ram_read_address;
  logic [AW:0]   count;
  logic [DW-1:0] ram_dout, out_data;
  logic          out_valid, busy, done;
  logic [DW-1:0] mem [DEPTH];

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  // external synchronous RAM: dout valid one cycle after the address
  always @(posedge clk) ram_dout <= mem[ram_read_address];

  mem_read_streamer #(.data_width(DW), .addr_width(AW)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .base_addr        (base_addr),
    .count            (count),
    .ram_read_address (ram_read_address),
    .ram_dout         (ram_dout),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .busy             (busy),
    .done             (done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic ready_for(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (k % 3 == 0);
    return 1'($urandom_range(0, 1));
  endfunction

  // mode 0: always ready, 1: ready 1,0,0 repeating, 2: random ready
  task automatic run_burst(input int b, input int c, input int mode, input bit poke);
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] prev_data;
    bit            prev_stall, seen_valid;
    int            done_at;
    for (int i = 0; i < c; i++) exp_q.push_back(mem[AW'((b + i) % DEPTH)]);
    @(negedge clk);
    check("idle_busy", 64'(busy), 0);
    start      = 1'b1;
    base_addr  = AW'(b);
    count      = (AW+1)'(c);
    out_ready  = ready_for(mode, 0);
    prev_stall = 1'b0;
    prev_data  = '0;
    seen_valid = 1'b0;
    done_at    = -1;
    for (int k = 1; k < 300 && done_at < 0; k++) begin
      @(negedge clk);
      if (done) done_at = k;
      check("busy", 64'(busy), 1);
      if (prev_stall) begin
        check("stall_valid", 64'(out_valid), 1);
        check("stall_data", 64'(out_data), 64'(prev_data));
      end
      if (out_valid && !seen_valid) begin
        seen_valid = 1'b1;
        check("first_valid_cycle", 64'(k), 3);
      end
      if (mode == 0 && k >= 3 && k < c + 3) check("no_bubble", 64'(out_valid), 1);
      out_ready = ready_for(mode, k);
      start     = poke && (c > 0) && (k == 2 || k == 4);
      base_addr = AW'($urandom);
      count     = (AW+1)'($urandom_range(0, DEPTH));
      if (exp_q.size() == 0) check("spurious_valid", 64'(out_valid), 0);
      else if (out_valid && out_ready) check("data", 64'(out_data), 64'(exp_q.pop_front()));
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
    start = 1'b0;
    if (done_at < 0) begin
      check("done_timeout", 0, 1);
    end else begin
      check("words_left", 64'(exp_q.size()), 0);
      if (mode == 0) check("done_cycle", 64'(done_at), (c == 0) ? 64'd1 : 64'(c + 4));
      @(negedge clk);
      check("done_pulse", 64'(done), 0);
      check("busy_after", 64'(busy), 0);
      check("valid_after", 64'(out_valid), 0);
    end
  endtask

  task automatic reset_mid_burst();
    @(negedge clk);
    start     = 1'b1;
    base_addr = '0;
    count     = (AW+1)'(8);
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_valid", 64'(out_valid), 0);
    check("rst_mid_busy", 64'(busy), 0);
    check("rst_mid_done", 64'(done), 0);
    check("rst_mid_addr", 64'(ram_read_address), 0);
    check("rst_mid_data", 64'(out_data), 0);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_no_stale", 64'(out_valid), 0);
    end
    run_burst(0, 2, 0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = DW'(32'h100 + i);
    // reset wins over a simultaneous start
    reset     = 1'b1;
    start     = 1'b1;
    base_addr = AW'(1);
    count     = (AW+1)'(3);
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(out_valid), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_addr", 64'(ram_read_address), 0);
    check("rst_data", 64'(out_data), 0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("rst_start_ignored", 64'(busy), 0);

    run_burst(2, 4, 0, 1'b0);
    run_burst(14, 4, 0, 1'b0);
    run_burst(5, 4, 1, 1'b0);
    run_burst(3, 0, 0, 1'b0);
    run_burst(7, 16, 0, 1'b0);
    run_burst(1, 5, 0, 1'b1);
    run_burst(9, 6, 2, 1'b1);
    reset_mid_burst();

    for (int n = 0; n < 25; n++) begin
      run_burst(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH)),
                int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
